// File: rtl/add_seq_arb_if.sv
// Bundle between the add_seq_arb controller, its two requesters and the shared
// 8-bit adder.
//   slave  : controller view (requests, operands, adder return in; grants,
//            status, result and adder drive out)
//   master : environment view (requesters plus the shared adder)
interface add_seq_arb_if #(
    parameter int unsigned NBYTES = 4
);
    localparam int unsigned W = 8 * NBYTES;

    logic         req0;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic         cin0;
    logic         req1;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         cin1;
    logic         gnt0;
    logic         gnt1;
    logic         busy;
    logic         done;
    logic         done_id;
    logic [W-1:0] sum;
    logic         cout;
    logic [7:0]   adder_a;
    logic [7:0]   adder_b;
    logic         adder_cin;
    logic [7:0]   adder_sum;
    logic         adder_cout;

    modport slave (
        input  req0, a0, b0, cin0, req1, a1, b1, cin1, adder_sum, adder_cout,
        output gnt0, gnt1, busy, done, done_id, sum, cout, adder_a, adder_b, adder_cin
    );

    modport master (
        output req0, a0, b0, cin0, req1, a1, b1, cin1, adder_sum, adder_cout,
        input  gnt0, gnt1, busy, done, done_id, sum, cout, adder_a, adder_b, adder_cin
    );
endinterface

// File: rtl/add_seq_arb.sv
// Round-robin arbiter plus byte-serial sequencer sharing one external 8-bit
// combinational adder between two requesters. Each accepted request performs
// {cout, sum} = a + b + cin over NBYTES bytes, LSB first, one byte per cycle.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset
//   bus    : add_seq_arb_if.slave -- requests/operands in, grants, busy,
//            done/done_id, registered sum/cout out, shared adder drive/return
module add_seq_arb #(
    parameter int unsigned NBYTES = 4
) (
    input logic          clk,
    input logic          reset,
    add_seq_arb_if.slave bus
);
    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_next;
    logic          carry_r;
    logic          owner;
    logic          last_id;
    logic          grant0;
    logic          grant1;

    // Grants are only offered in idle; on contention the requester that did
    // not win last time gets the adder.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == StIdle && !reset) begin
            grant0 = bus.req0 && (!bus.req1 || last_id);
            grant1 = bus.req1 && (!bus.req0 || !last_id);
        end
    end

    assign bus.gnt0 = grant0;
    assign bus.gnt1 = grant1;

    // Accumulator with the current adder byte merged in; the last byte goes
    // straight into sum so the result is ready on the edge entering done.
    always_comb begin
        acc_next = acc;
        acc_next[{idx, 3'b000} +: 8] = bus.adder_sum;
    end

    always_comb begin
        bus.adder_a   = '0;
        bus.adder_b   = '0;
        bus.adder_cin = 1'b0;
        if (state == StRun) begin
            bus.adder_a   = a_r[{idx, 3'b000} +: 8];
            bus.adder_b   = b_r[{idx, 3'b000} +: 8];
            bus.adder_cin = carry_r;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            idx         <= '0;
            a_r         <= '0;
            b_r         <= '0;
            acc         <= '0;
            carry_r     <= 1'b0;
            owner       <= 1'b0;
            last_id     <= 1'b1;
            bus.sum     <= '0;
            bus.cout    <= 1'b0;
            bus.done    <= 1'b0;
            bus.done_id <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (grant0 || grant1) begin
                        a_r      <= grant1 ? bus.a1 : bus.a0;
                        b_r      <= grant1 ? bus.b1 : bus.b0;
                        carry_r  <= grant1 ? bus.cin1 : bus.cin0;
                        owner    <= grant1;
                        last_id  <= grant1;
                        idx      <= '0;
                        bus.busy <= 1'b1;
                        state    <= StRun;
                    end
                end
                StRun: begin
                    acc     <= acc_next;
                    carry_r <= bus.adder_cout;
                    if (idx == LAST) begin
                        idx         <= '0;
                        bus.sum     <= acc_next;
                        bus.cout    <= bus.adder_cout;
                        bus.done    <= 1'b1;
                        bus.done_id <= owner;
                        state       <= StDone;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                StDone: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_add_seq_arb.sv
// Self-checking bench for add_seq_arb: hand-computed vector table, directed
// multi-cycle sequences (contention, busy hold-off, mid-run reset) and a
// randomized phase against an arithmetic/round-robin reference model.
module tb_add_seq_arb;
    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    typedef struct {
        bit           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    add_seq_arb_if #(.NBYTES(NBYTES)) bus ();

    add_seq_arb #(.NBYTES(NBYTES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // The shared combinational adder.
    assign {bus.adder_cout, bus.adder_sum} =
        {1'b0, bus.adder_a} + {1'b0, bus.adder_b} + {8'd0, bus.adder_cin};

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic set_req(input bit id, input logic r, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic c);
        if (id) begin
            bus.req1 = r; bus.a1 = a; bus.b1 = b; bus.cin1 = c;
        end else begin
            bus.req0 = r; bus.a0 = a; bus.b0 = b; bus.cin0 = c;
        end
    endtask

    // Carry entering byte k: carry out of the low 8*k bits of a + b + cin.
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin, input int k);
        logic [W:0] one;
        logic [W:0] mask;
        logic [W:0] lo;
        one  = (W+1)'(1);
        mask = (one << (8 * k)) - one;
        lo   = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {{W{1'b0}}, cin};
        return lo[8*k];
    endfunction

    // One complete transaction for a lone requester, checked cycle by cycle.
    task automatic op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input string tag);
        logic [W:0] want;
        int         n;
        want = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        set_req(id, 1'b1, a, b, cin);
        #1;
        n = 0;
        while ((id ? bus.gnt1 : bus.gnt0) !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chkb({tag, " gnt"}, id ? bus.gnt1 : bus.gnt0, 1'b1);
        chkb({tag, " other gnt"}, id ? bus.gnt0 : bus.gnt1, 1'b0);
        tick();
        set_req(id, 1'b0, a, b, cin);
        for (int k = 0; k < NBYTES; k++) begin
            chkb({tag, " busy"}, bus.busy, 1'b1);
            chkb({tag, " early done"}, bus.done, 1'b0);
            chk8({tag, " adder_a"}, bus.adder_a, a[8*k +: 8]);
            chk8({tag, " adder_b"}, bus.adder_b, b[8*k +: 8]);
            chkb({tag, " adder_cin"}, bus.adder_cin, carry_into(a, b, cin, k));
            tick();
        end
        chkb({tag, " done"}, bus.done, 1'b1);
        chkb({tag, " done_id"}, bus.done_id, id);
        chkb({tag, " busy in done"}, bus.busy, 1'b1);
        chkv({tag, " result"}, {bus.cout, bus.sum}, want);
        tick();
        chkb({tag, " done drop"}, bus.done, 1'b0);
        chkb({tag, " busy drop"}, bus.busy, 1'b0);
        chkv({tag, " result held"}, {bus.cout, bus.sum}, want);
    endtask

    initial begin
        vec_t         vecs[7];
        logic [W:0]   want;
        logic [W:0]   want0;
        logic [W:0]   want1;
        int           ngnt;
        int           ndone;
        int           gcyc[4];
        int           gid[4];
        bit           pend0;
        bit           pend1;
        bit           mlast;
        bit           win;
        logic [W-1:0] pa0, pb0, pa1, pb1;
        logic         pc0, pc1;

        vecs[0] = '{id: 1'b0, a: 32'h000000FF, b: 32'h00000001, cin: 1'b0,
                    sum: 32'h00000100, cout: 1'b0};
        vecs[1] = '{id: 1'b1, a: 32'hFFFFFFFF, b: 32'h00000000, cin: 1'b1,
                    sum: 32'h00000000, cout: 1'b1};
        vecs[2] = '{id: 1'b0, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, cin: 1'b1,
                    sum: 32'hFFFFFFFF, cout: 1'b1};
        vecs[3] = '{id: 1'b1, a: 32'h12345678, b: 32'h11111111, cin: 1'b0,
                    sum: 32'h23456789, cout: 1'b0};
        vecs[4] = '{id: 1'b0, a: 32'h80000000, b: 32'h80000000, cin: 1'b0,
                    sum: 32'h00000000, cout: 1'b1};
        vecs[5] = '{id: 1'b1, a: 32'h00FF00FF, b: 32'h00010001, cin: 1'b1,
                    sum: 32'h01000101, cout: 1'b0};
        vecs[6] = '{id: 1'b0, a: 32'h00000000, b: 32'h00000000, cin: 1'b0,
                    sum: 32'h00000000, cout: 1'b0};

        pa0 = '0; pb0 = '0; pa1 = '0; pb1 = '0; pc0 = 1'b0; pc1 = 1'b0;
        set_req(1'b0, 1'b0, '0, '0, 1'b0);
        set_req(1'b1, 1'b0, '0, '0, 1'b0);
        reset = 1'b1;

        // Reset: grants suppressed even with a request pending.
        tick();
        bus.req0 = 1'b1;
        #1;
        chkb("gnt0 during reset", bus.gnt0, 1'b0);
        bus.req0 = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chkb("reset busy", bus.busy, 1'b0);
        chkb("reset done", bus.done, 1'b0);
        chkb("reset done_id", bus.done_id, 1'b0);
        chkv("reset result", {bus.cout, bus.sum}, '0);
        chk8("reset adder_a", bus.adder_a, 8'h00);
        chk8("reset adder_b", bus.adder_b, 8'h00);
        chkb("reset adder_cin", bus.adder_cin, 1'b0);
        chkb("reset gnt0", bus.gnt0, 1'b0);
        chkb("reset gnt1", bus.gnt1, 1'b0);
        tick();

        // Vector table.
        for (int i = 0; i < 7; i++) begin
            op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin, $sformatf("vec%0d", i));
            chkv($sformatf("vec%0d table", i), {bus.cout, bus.sum},
                 {vecs[i].cout, vecs[i].sum});
        end

        // Both requesters held from reset release: alternate every NBYTES+2 cycles.
        reset = 1'b1;
        set_req(1'b0, 1'b1, 32'h0000F00D, 32'h00001234, 1'b0);
        set_req(1'b1, 1'b1, 32'hCAFE0000, 32'h40000001, 1'b1);
        want0 = 33'h00001_0241;
        want1 = 33'h10AFE0002;
        tick();
        tick();
        reset = 1'b0;
        #1;
        ngnt  = 0;
        ndone = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (bus.gnt0 || bus.gnt1) begin
                if (ngnt < 4) begin
                    gcyc[ngnt] = cyc;
                    gid[ngnt]  = bus.gnt1 ? 1 : 0;
                end
                ngnt++;
            end
            if (bus.done) begin
                chkb("contend done_id", bus.done_id, (ndone % 2) == 1);
                chkv("contend result", {bus.cout, bus.sum}, ((ndone % 2) == 1) ? want1 : want0);
                ndone++;
            end
            tick();
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chki("contend grant count", ngnt, 4);
        chki("contend done count", ndone, 4);
        for (int j = 0; j < 4; j++) begin
            if (j < ngnt) begin
                chki($sformatf("contend grant%0d cycle", j), gcyc[j], 6 * j);
                chki($sformatf("contend grant%0d id", j), gid[j], j % 2);
            end
        end
        tick();

        // Requester 1 held off while busy; requester 0 operands changed mid-run.
        set_req(1'b0, 1'b1, 32'h01020304, 32'h10203040, 1'b0);
        #1;
        chkb("hold gnt0", bus.gnt0, 1'b1);
        tick();
        bus.req0 = 1'b0;
        for (int k = 0; k < NBYTES; k++) begin
            if (k == 1) set_req(1'b1, 1'b1, 32'h0000FFFF, 32'h00000001, 1'b0);
            if (k == 2) begin
                bus.a0 = 32'hFFFFFFFF;
                bus.b0 = 32'hFFFFFFFF;
            end
            #1;
            chkb("hold gnt1 in run", bus.gnt1, 1'b0);
            tick();
        end
        chkb("hold done", bus.done, 1'b1);
        chkb("hold done_id", bus.done_id, 1'b0);
        chkb("hold gnt1 in done", bus.gnt1, 1'b0);
        chkv("hold result", {bus.cout, bus.sum}, 33'h0_11223344);
        tick();
        chkb("hold gnt1 after done", bus.gnt1, 1'b1);
        tick();
        bus.req1 = 1'b0;
        repeat (NBYTES) tick();
        chkb("hold second done", bus.done, 1'b1);
        chkb("hold second done_id", bus.done_id, 1'b1);
        chkv("hold second result", {bus.cout, bus.sum}, 33'h0_00010000);
        tick();

        // Reset in the run cycle with idx = 2 aborts the add.
        set_req(1'b0, 1'b1, 32'hAAAA5555, 32'h12345678, 1'b1);
        #1;
        chkb("abort gnt0", bus.gnt0, 1'b1);
        tick();
        bus.req0 = 1'b0;
        tick();
        tick();
        chk8("abort adder_a idx2", bus.adder_a, 8'hAA);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chkb("abort done", bus.done, 1'b0);
        chkb("abort busy", bus.busy, 1'b0);
        chkv("abort result", {bus.cout, bus.sum}, '0);
        chkb("abort adder_cin", bus.adder_cin, 1'b0);
        repeat (NBYTES + 1) begin
            tick();
            chkb("abort no done", bus.done, 1'b0);
        end
        op(1'b0, 32'h00000001, 32'h00000002, 1'b0, "post-abort");

        // Randomized phase against the round-robin / arithmetic model.
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        pend0 = 1'b0;
        pend1 = 1'b0;
        mlast = 1'b1;
        for (int it = 0; it < 60; it++) begin
            if (!pend0 && $urandom_range(0, 2) != 0) begin
                pend0 = 1'b1;
                pa0   = W'($urandom);
                pb0   = W'($urandom);
                pc0   = 1'($urandom_range(0, 1));
            end
            if (!pend1 && $urandom_range(0, 2) != 0) begin
                pend1 = 1'b1;
                pa1   = W'($urandom);
                pb1   = W'($urandom);
                pc1   = 1'($urandom_range(0, 1));
            end
            set_req(1'b0, pend0, pa0, pb0, pc0);
            set_req(1'b1, pend1, pa1, pb1, pc1);
            #1;
            if (!pend0 && !pend1) begin
                chkb("rand idle gnt", bus.gnt0 | bus.gnt1, 1'b0);
                tick();
                continue;
            end
            win = (pend0 && pend1) ? !mlast : pend1;
            chkb("rand gnt0", bus.gnt0, !win);
            chkb("rand gnt1", bus.gnt1, win);
            want = win ? ({1'b0, pa1} + {1'b0, pb1} + {{W{1'b0}}, pc1})
                       : ({1'b0, pa0} + {1'b0, pb0} + {{W{1'b0}}, pc0});
            tick();
            mlast = win;
            // The winner drops its request and scribbles over its operands.
            if (win) begin
                pend1 = 1'b0;
                set_req(1'b1, 1'b0, W'($urandom), W'($urandom), 1'b1);
            end else begin
                pend0 = 1'b0;
                set_req(1'b0, 1'b0, W'($urandom), W'($urandom), 1'b1);
            end
            repeat (NBYTES) begin
                chkb("rand gnt while busy", bus.gnt0 | bus.gnt1, 1'b0);
                tick();
            end
            chkb("rand done", bus.done, 1'b1);
            chkb("rand done_id", bus.done_id, win);
            chkv("rand result", {bus.cout, bus.sum}, want);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/add_seq_arb.md
Name: add_seq_arb

Overview:
Round-robin arbiter and byte-serial sequencer that shares one external combinational 8-bit ripple-carry adder between two requesters. Each accepted request is a multi-precision add of NBYTES*8-bit operands. The controller drives the adder one byte per cycle, least-significant byte first, and chains the carry through a register. It sits between requesting units and the shared adder datapath.

Parameters:
NBYTES, 4, operand width in bytes (>=1); operand/sum width W = 8*NBYTES

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req0  input  1  requester 0 request; level, held until gnt0
a0  input  W  requester 0 operand A
b0  input  W  requester 0 operand B
cin0  input  1  requester 0 carry-in
req1  input  1  requester 1 request; level, held until gnt1
a1  input  W  requester 1 operand A
b1  input  W  requester 1 operand B
cin1  input  1  requester 1 carry-in
gnt0  output  1  1-cycle accept pulse to requester 0 (combinational in IDLE)
gnt1  output  1  1-cycle accept pulse to requester 1
busy  output  1  high in RUN and DONE
done  output  1  1-cycle result-valid pulse
done_id  output  1  requester owning current result
sum  output  W  result, registered
cout  output  1  final carry-out, registered
adder_a  output  8  byte to shared adder A input
adder_b  output  8  byte to shared adder B input
adder_cin  output  1  carry to shared adder
adder_sum  input  8  shared adder sum (combinational return)
adder_cout  input  1  shared adder carry-out

Behaviour:
- Reset (sync, active-high, overrides everything): state=IDLE, idx=0, carry_r=0, sum=0, cout=0, done=0, done_id=0, busy=0, last_id=1. With last_id=1, requester 0 wins the first contention.
- gnt0/gnt1 are 0 outside IDLE and 0 while reset is high. At most one grant is high per cycle.
- IDLE:
  - req0 only -> gnt0.
  - req1 only -> gnt1.
  - Both -> grant the id != last_id.
  - On the grant edge: capture the winner's a/b into a_r/b_r and its cin into carry_r; set owner and last_id to the winner; idx=0; go to RUN.
  - No request -> stay in IDLE.
- RUN:
  - adder_a = a_r byte idx, adder_b = b_r byte idx, adder_cin = carry_r.
  - Each edge: acc byte idx <= adder_sum; carry_r <= adder_cout; idx++.
  - After byte NBYTES-1 -> DONE.
  - idx wraps to 0 on leaving RUN.
- DONE:
  - done=1 and done_id=owner for this single cycle.
  - sum/cout are loaded on the edge entering DONE: sum = acc, with the final byte taken directly from adder_sum; cout = adder_cout.
  - sum/cout are held until the next DONE load.
  - Next state is IDLE.
- Timing: grant in cycle T -> RUN cycles T+1..T+NBYTES -> done in cycle T+NBYTES+1. The earliest next grant is T+NBYTES+2. Back-to-back throughput is one add per NBYTES+2 cycles.
- adder_a/adder_b/adder_cin are 0 when not in RUN.
- Requests arriving while busy are ignored and not queued; the requester keeps req high until granted. Operands are sampled only on the grant edge; later input changes do not affect the operation in progress.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(W+1). No overflow flag.
- Reset asserted mid-RUN/DONE aborts the operation: no done, outputs cleared as at reset.

Test Plan:
- Reset for 2 cycles, then idle -> all outputs 0; adder_* = 0; gnt0 = gnt1 = 0.
- req0, a0=0x000000FF, b0=0x00000001, cin0=0, granted at T -> adder_cin sequence 0,1,0,0 in T+1..T+4; done at T+5 with sum=0x00000100, cout=0, done_id=0.
- req1, a1=0xFFFFFFFF, b1=0x00000000, cin1=1 -> done after 5 cycles with sum=0x00000000, cout=1, done_id=1; sum held after done falls.
- req0 and req1 both held high from reset release with distinct operands -> grants 0,1,0,1 at cycles T, T+6, T+12, T+18; each result matches its owner's operands.
- req1 raised during requester 0's RUN -> gnt1 stays 0 until the IDLE cycle after done, then pulses; changing a0 mid-RUN leaves the result unchanged.
- reset pulsed in RUN cycle idx=2 -> no done pulse; sum=0, cout=0, busy=0 next cycle; a fresh req0 is granted normally afterwards.
